// File: rtl/seq_det_pkg.sv
// Shared definitions for the time-shared 101 detector scheduler:
// FSM state encoding and the default drain length.
package seq_det_pkg;

  localparam int DRAIN_CYC_DEFAULT = 1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_CLEAR = 3'd1,
    ST_SHIFT = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_e;

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the first requester after the last one served.
// The pointer advances only when the owner commits a grant via upd_i.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_i,
  input  logic            upd_i,
  output logic [NREQ-1:0] gnt_o
);

  localparam int PW = $clog2(NREQ);

  logic [PW-1:0] last_q;
  logic [PW-1:0] win_d;
  logic [PW-1:0] idx;

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    gnt_o = '0;
    win_d = last_q;
    idx   = '0;
    for (int off = NREQ; off >= 1; off--) begin
      idx = PW'((int'(last_q) + off) % NREQ);
      if (req_i[idx]) begin
        gnt_o      = '0;
        gnt_o[idx] = 1'b1;
        win_d      = idx;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= PW'(NREQ - 1);
    end else if (upd_i && (|req_i)) begin
      last_q <= win_d;
    end
  end

endmodule

// File: rtl/seq_det_sched.sv
// Time-shares one bit-serial 101 detector among NREQ requesters: clear,
// shift the granted word MSB-first, count hits, report with a done pulse.
module seq_det_sched
  import seq_det_pkg::*;
#(
  parameter int NREQ      = 2,
  parameter int WORD_W    = 15,
  parameter int CNT_W     = 4,
  parameter int DRAIN_CYC = DRAIN_CYC_DEFAULT
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*WORD_W-1:0]   req_word,
  output logic [NREQ-1:0]          gnt,
  output logic                     det_rst,
  output logic                     det_x,
  input  logic                     det_y,
  output logic                     done,
  output logic [$clog2(NREQ)-1:0]  done_id,
  output logic [CNT_W-1:0]         match_cnt
);

  localparam int IDW     = $clog2(NREQ);
  localparam int CYC_MAX = (WORD_W > DRAIN_CYC) ? WORD_W : DRAIN_CYC;
  localparam int CYC_W   = $clog2(CYC_MAX + 1);

  state_e            state_q;
  logic [NREQ-1:0]   gnt_q;
  logic              det_rst_q;
  logic              det_x_q;
  logic              done_q;
  logic [IDW-1:0]    done_id_q;
  logic [IDW-1:0]    id_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WORD_W-1:0] sh_q;
  logic [CYC_W-1:0]  cyc_q;

  logic [NREQ-1:0]   arb_gnt;
  logic              arb_upd;
  logic [IDW-1:0]    win_id;
  logic [WORD_W-1:0] win_word;
  logic              fin;

  assign arb_upd = (state_q == ST_IDLE) && (|req);

  rr_arbiter #(.NREQ(NREQ)) u_arb (
    .clk   (clk),
    .rst_n (rst),
    .req_i (req),
    .upd_i (arb_upd),
    .gnt_o (arb_gnt)
  );

  always_comb begin
    win_id   = '0;
    win_word = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (arb_gnt[i]) begin
        win_id   = IDW'(i);
        win_word = req_word[i*WORD_W +: WORD_W];
      end
    end
  end

  // Last counted cycle of a job: end of DRAIN, or end of SHIFT when there is no drain.
  assign fin = ((state_q == ST_SHIFT) && (cyc_q == CYC_W'(WORD_W - 1)) && (DRAIN_CYC == 0)) ||
               ((state_q == ST_DRAIN) && (cyc_q == CYC_W'(DRAIN_CYC - 1)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      gnt_q     <= '0;
      det_rst_q <= 1'b0;
      det_x_q   <= 1'b0;
      done_q    <= 1'b0;
      done_id_q <= '0;
      id_q      <= '0;
      cnt_q     <= '0;
      sh_q      <= '0;
      cyc_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (((state_q == ST_SHIFT) || (state_q == ST_DRAIN)) && det_y && !(&cnt_q)) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (fin) begin
        state_q   <= ST_DONE;
        done_q    <= 1'b1;
        done_id_q <= id_q;
        gnt_q     <= '0;
        det_rst_q <= 1'b0;
        det_x_q   <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (|req) begin
              gnt_q   <= arb_gnt;
              id_q    <= win_id;
              sh_q    <= win_word;
              cnt_q   <= '0;
              state_q <= ST_CLEAR;
            end
          end
          ST_CLEAR: begin
            state_q   <= ST_SHIFT;
            det_rst_q <= 1'b1;
            det_x_q   <= sh_q[WORD_W-1];
            sh_q      <= {sh_q[WORD_W-2:0], 1'b0};
            cyc_q     <= '0;
          end
          ST_SHIFT: begin
            det_x_q <= sh_q[WORD_W-1];
            sh_q    <= {sh_q[WORD_W-2:0], 1'b0};
            cyc_q   <= cyc_q + CYC_W'(1);
            if (cyc_q == CYC_W'(WORD_W - 1)) begin
              state_q <= ST_DRAIN;
              det_x_q <= 1'b0;
              cyc_q   <= '0;
            end
          end
          ST_DRAIN: cyc_q <= cyc_q + CYC_W'(1);
          ST_DONE:  state_q <= ST_IDLE;
          default:  state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign gnt       = gnt_q;
  assign det_rst   = det_rst_q;
  assign det_x     = det_x_q;
  assign done      = done_q;
  assign done_id   = done_id_q;
  assign match_cnt = cnt_q;

endmodule

// File: tb/tb_seq_det_sched.sv
// Randomized + directed bench for seq_det_sched: a job-level timeline model
// predicts every output; a second instance covers saturation and no-drain Moore.
module tb_seq_det_sched;

  localparam int WA = 15, NA = 2, CA = 4, DA = 1;
  localparam int DONE_P = WA + 2 + DA;
  localparam int NB = 3, CB = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_a, rst_b;
  logic [NA-1:0]     req_a, gnt_a;
  logic [NA*WA-1:0]  word_a;
  logic              det_rst_a, det_x_a, det_y_a, done_a;
  logic [0:0]        done_id_a;
  logic [CA-1:0]     cnt_a;
  logic              mealy_sel;

  logic [NB-1:0]     req_b, gnt_b;
  logic [NB*WA-1:0]  word_b;
  logic              det_rst_b, det_x_b, det_y_b, done_b;
  logic [1:0]        done_id_b;
  logic [CB-1:0]     cnt_b;

  seq_det_sched #(.NREQ(NA), .WORD_W(WA), .CNT_W(CA), .DRAIN_CYC(DA)) dut_a (
    .clk(clk), .rst(rst_a), .req(req_a), .req_word(word_a), .gnt(gnt_a),
    .det_rst(det_rst_a), .det_x(det_x_a), .det_y(det_y_a), .done(done_a),
    .done_id(done_id_a), .match_cnt(cnt_a)
  );

  seq_det_sched #(.NREQ(NB), .WORD_W(WA), .CNT_W(CB), .DRAIN_CYC(0)) dut_b (
    .clk(clk), .rst(rst_b), .req(req_b), .req_word(word_b), .gnt(gnt_b),
    .det_rst(det_rst_b), .det_x(det_x_b), .det_y(det_y_b), .done(done_b),
    .done_id(done_id_b), .match_cnt(cnt_b)
  );

  // Behavioural 101 detectors: two-bit history, Mealy combinational, Moore registered.
  logic [1:0] hist_a, hist_b;
  logic       moore_a, moore_b;
  always @(posedge clk or negedge det_rst_a) begin
    if (!det_rst_a) begin hist_a <= 2'b00; moore_a <= 1'b0; end
    else begin hist_a <= {hist_a[0], det_x_a}; moore_a <= (hist_a == 2'b10) && det_x_a; end
  end
  always @(posedge clk or negedge det_rst_b) begin
    if (!det_rst_b) begin hist_b <= 2'b00; moore_b <= 1'b0; end
    else begin hist_b <= {hist_b[0], det_x_b}; moore_b <= (hist_b == 2'b10) && det_x_b; end
  end
  assign det_y_a = mealy_sel ? ((hist_a == 2'b10) && det_x_a) : moore_a;
  assign det_y_b = moore_b;

  int n_checks = 0, n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Overlapping 101 occurrences in the MSB-first bit stream, saturated.
  function automatic int count101(input logic [WA-1:0] w, input bit incl_last, input int cmax);
    int n;
    logic [2:0] win;
    n = 0;
    for (int k = 2; k < WA; k++) begin
      win = 3'(w >> (WA - 1 - k));
      if (win == 3'b101 && (incl_last || k != WA - 1)) n++;
    end
    return (n > cmax) ? cmax : n;
  endfunction

  function automatic int rr_pick(input logic [NA-1:0] r, input int last);
    for (int off = 1; off <= NA; off++) begin
      if (|(r & (NA'(1) << ((last + off) % NA)))) return (last + off) % NA;
    end
    return 0;
  endfunction

  // Job timeline model: m_p counts cycles into the job (1 = CLEAR .. DONE_P = DONE).
  int            m_p, m_last, m_id, m_hold_id, m_hold_cnt;
  logic [WA-1:0] m_word;
  always @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      m_p <= 0; m_last <= NA - 1; m_id <= 0; m_hold_id <= 0; m_hold_cnt <= 0; m_word <= '0;
    end else if (m_p == 0) begin
      if (req_a != '0) begin
        m_id   <= rr_pick(req_a, m_last);
        m_last <= rr_pick(req_a, m_last);
        m_word <= WA'(word_a >> (rr_pick(req_a, m_last) * WA));
        m_p    <= 1;
      end
    end else if (m_p == DONE_P) begin
      m_p <= 0;
    end else begin
      m_p <= m_p + 1;
      if (m_p + 1 == DONE_P) begin
        m_hold_id  <= m_id;
        m_hold_cnt <= count101(m_word, 1'b1, (1 << CA) - 1);
      end
    end
  end

  always @(negedge clk) begin
    check_eq("gnt_a", gnt_a, (m_p >= 1 && m_p < DONE_P) ? (NA'(1) << m_id) : '0);
    check_eq("det_rst_a", det_rst_a, (m_p >= 2 && m_p < DONE_P));
    check_eq("det_x_a", det_x_a, (m_p >= 2 && m_p <= WA + 1) ? 1'(m_word >> (WA + 1 - m_p)) : 1'b0);
    check_eq("done_a", done_a, m_p == DONE_P);
    if (m_p == 0 || m_p == DONE_P) begin
      check_eq("match_cnt_a", cnt_a, m_hold_cnt);
      check_eq("done_id_a", done_id_a, m_hold_id);
    end
    if (done_a) $display("job A: id=%0d match_cnt=%0d mealy=%0d", done_id_a, cnt_a, mealy_sel);
  end

  task automatic job_a(input int id, input logic [WA-1:0] w, input logic sel, input bit scramble);
    int tg;
    bit got;
    mealy_sel = sel;
    word_a[id*WA +: WA] = w;
    req_a = req_a | (NA'(1) << id);
    tg = -1;
    got = 1'b0;
    for (int t = 0; t < 60 && !got; t++) begin
      @(negedge clk);
      if (tg < 0 && gnt_a != '0) begin
        tg = t;
        req_a = '0;
        if (scramble) word_a = ~word_a;
      end
      if (done_a) begin
        got = 1'b1;
        check_eq("a_latency", t - tg, 17);
      end
    end
    check_eq("a_job_done", got, 1);
  endtask

  task automatic pulse_reset_a();
    @(negedge clk);
    #2 rst_a = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst_a = 1'b1;
  endtask

  logic [WA-1:0] wb [3];
  int seen, tg_b;

  initial begin
    rst_a = 1'b0; rst_b = 1'b0;
    req_a = '0; req_b = '0; word_a = '0; word_b = '0; mealy_sel = 1'b1;
    repeat (3) @(negedge clk);
    #2 rst_a = 1'b1; rst_b = 1'b1;

    // Instance B: 3 requesters, CNT_W=2, no drain, Moore detector.
    wb[0] = 15'h0005; wb[1] = 15'h5555; wb[2] = 15'h0028;
    word_b = {wb[2], wb[1], wb[0]};
    req_b = 3'b111;
    seen = 0; tg_b = -1;
    for (int t = 0; t < 200 && seen < 3; t++) begin
      @(negedge clk);
      if (gnt_b != '0 && tg_b < 0) tg_b = t;
      if (done_b) begin
        if (seen == 0) check_eq("b_latency", t - tg_b, 16);
        check_eq("b_done_id", done_id_b, seen);
        check_eq("b_match_cnt", cnt_b, count101(wb[seen], 1'b0, (1 << CB) - 1));
        $display("job B: id=%0d match_cnt=%0d", done_id_b, cnt_b);
        seen++;
        if (seen == 3) req_b = '0;
      end
    end
    check_eq("b_jobs_done", seen, 3);

    // Directed jobs on instance A.
    job_a(0, 15'h3A54, 1'b1, 1'b0);
    job_a(0, 15'h3A54, 1'b0, 1'b0);
    job_a(1, 15'h5555, 1'b1, 1'b1);

    // Contention from a fresh reset: grants alternate starting at index 0.
    pulse_reset_a();
    word_a = {15'h0000, 15'h5555};
    req_a = 2'b11;
    seen = 0;
    for (int t = 0; t < 120 && seen < 4; t++) begin
      @(negedge clk);
      if (done_a) begin
        check_eq("rr_done_id", done_id_a, seen % 2);
        check_eq("rr_match_cnt", cnt_a, (seen % 2 == 0) ? 7 : 0);
        seen++;
        if (seen == 4) req_a = '0;
      end
    end
    check_eq("rr_jobs_done", seen, 4);

    // Abort during SHIFT bit 6, then a fresh job.
    @(negedge clk);
    mealy_sel = 1'b1;
    word_a[0 +: WA] = 15'h3A54;
    req_a = 2'b01;
    for (int t = 0; t < 40 && m_p != 8; t++) begin
      @(negedge clk);
      if (gnt_a != '0) req_a = '0;
    end
    check_eq("abort_reached_bit6", m_p, 8);
    #2 rst_a = 1'b0;
    @(negedge clk);
    check_eq("abort_no_done", done_a, 0);
    check_eq("abort_gnt_clear", gnt_a, 0);
    @(negedge clk);
    #2 rst_a = 1'b1;
    job_a(0, 15'h3A54, 1'b1, 1'b0);

    // Random traffic: requests held until granted, words churn every cycle.
    for (int c = 0; c < 500; c++) begin
      @(negedge clk);
      for (int i = 0; i < NA; i++) begin
        if (((gnt_a & (NA'(1) << i)) != '0) && ($urandom_range(1, 0) == 1))
          req_a = req_a & ~(NA'(1) << i);
        else if (((req_a & (NA'(1) << i)) == '0) && ($urandom_range(3, 0) == 0))
          req_a = req_a | (NA'(1) << i);
      end
      if ($urandom_range(3, 0) == 0) word_a = {2{15'h5555 ^ WA'($urandom_range(15, 0))}};
      else word_a = (NA*WA)'({$urandom(), $urandom()});
      if (m_p == 0 && $urandom_range(7, 0) == 0) mealy_sel = ~mealy_sel;
    end
    req_a = '0;
    for (int t = 0; t < 40 && m_p != 0; t++) @(negedge clk);
    check_eq("final_idle", m_p, 0);
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
